// File: rtl/hilo_sequencer.sv
// Iterative HI/LO unit for MULT/MULTU/DIV/DIVU: one shift-add or restoring
// shift-subtract step per cycle, then a sign-fix cycle before HI/LO commit.
module hilo_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hilo_rd,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       dbg_state
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Handshake: start is a level sampled at each rising edge and is only
    // consumed while state is IDLE or DONE; done is a one-cycle pulse.
    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               neg_a_q, neg_a_d;
    logic               neg_b_q, neg_b_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               in_is_div;
    logic               in_signed;
    logic               in_neg_a;
    logic               in_neg_b;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] div_next;

    logic               neg_res;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    always_comb begin
        in_is_div = op[1];
        in_signed = ~op[0];
        in_neg_a  = in_signed & a[WIDTH-1];
        in_neg_b  = in_signed & b[WIDTH-1];
        a_mag     = in_neg_a ? -a : a;
        b_mag     = in_neg_b ? -b : b;
    end

    // Multiply: acc = {partial high, multiplier}; the W+1-bit sum keeps the carry.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    end

    // Divide: acc = {remainder, dividend/quotient}; quotient bits enter at the bottom.
    always_comb begin
        div_shift = acc_q[2*WIDTH-1:WIDTH-1];
        div_ge    = (div_shift >= {1'b0, opnd_q});
        div_diff  = div_shift - {1'b0, opnd_q};
        div_rem   = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        div_next  = {div_rem, acc_q[WIDTH-2:0], div_ge};
    end

    // Sign flags are only ever set for signed ops, so unsigned results pass through.
    always_comb begin
        neg_res  = neg_a_q ^ neg_b_q;
        prod_fix = neg_res ? -acc_q : acc_q;
        quo_fix  = neg_res ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = neg_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        if (op_q[1]) begin
            fix_hi = rem_fix;
            fix_lo = quo_fix;
        end else begin
            fix_hi = prod_fix[2*WIDTH-1:WIDTH];
            fix_lo = prod_fix[WIDTH-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        opnd_d  = opnd_q;
        acc_d   = acc_q;
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    op_d    = op;
                    neg_a_d = in_neg_a;
                    neg_b_d = in_neg_b;
                    cnt_d   = '0;
                    opnd_d  = in_is_div ? b_mag : a_mag;
                    acc_d   = {{WIDTH{1'b0}}, (in_is_div ? a_mag : b_mag)};
                    if (in_is_div && (b == '0)) begin
                        hi_d    = a;
                        lo_d    = '1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                acc_d = op_q[1] ? div_next : mul_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                hi_d    = fix_hi;
                lo_d    = fix_lo;
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            opnd_q  <= '0;
            acc_q   <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Stall only while computing, so mfhi/mflo in the done cycle sees new values.
    assign busy      = (state_q == S_RUN) || (state_q == S_FIX);
    assign stall     = busy && (start || hilo_rd);
    assign done      = (state_q == S_DONE);
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign dbg_state = state_q;

endmodule
